// File: rtl/wb_uart_tx.sv
// Wishbone byte-stream transmitter: bus writes fill a small TX FIFO that is
// serialised 8N1 on o_tx, with status, overrun flag and a programmable baud divisor.
module wb_uart_tx #(
  parameter int unsigned DIV_RESET  = 234,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rstn,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_tx,
  output logic        o_tx_idle
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_INIT = 16'(DIV_RESET);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          r_ack;
  logic [31:0]   r_rdt;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overrun;
  logic [15:0]   r_div;
  logic [1:0]    r_state;
  logic [15:0]   r_cnt;
  logic [15:0]   r_div_lat;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;
  logic          r_tx_idle;

  logic          w_acc;
  logic          w_wr;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_push;
  logic          w_pop;
  logic          w_phase_end;
  logic          w_ovr_clr;
  logic          w_div_we;
  logic [15:0]   w_div_wr;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_acc       = i_wb_cyc & ~r_ack;
  assign w_wr        = w_acc & i_wb_we;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FULL_CNT);
  assign w_push_req  = w_wr & (i_wb_adr[3:2] == 2'd0) & i_wb_sel[0];
  assign w_push      = w_push_req & ~w_full;
  assign w_phase_end = (r_cnt == '0);
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_phase_end));
  assign w_ovr_clr   = w_wr & (i_wb_adr[3:2] == 2'd1) & i_wb_sel[0] & i_wb_dat[7];
  assign w_div_we    = w_wr & (i_wb_adr[3:2] == 2'd2) & (i_wb_sel[0] | i_wb_sel[1]);
  assign w_div_wr    = {i_wb_sel[1] ? i_wb_dat[15:8] : r_div[15:8],
                        i_wb_sel[0] ? i_wb_dat[7:0]  : r_div[7:0]};
  assign w_unused    = ^{i_wb_dat[31:16], i_wb_sel[3:2], i_wb_adr[1:0]};

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_empty;
    w_status[1]    = w_full;
    w_status[2]    = (r_state != S_IDLE);
    w_status[7]    = r_overrun;
    w_status[11:8] = 4'(r_count);
  end

  always_comb begin
    w_rdata = '0;
    case (i_wb_adr[3:2])
      2'd1:    w_rdata = w_status;
      2'd2:    w_rdata = {16'h0000, r_div};
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rstn) begin
    if (!wb_rstn) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
      r_div <= DIV_INIT;
    end else begin
      r_ack <= w_acc;
      r_rdt <= (w_acc & ~i_wb_we) ? w_rdata : '0;
      if (w_div_we) r_div <= (w_div_wr == '0) ? 16'd1 : w_div_wr;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wb_dat[7:0];
  end

  // A push into a full FIFO is dropped even when the shifter pops on the same edge.
  always_ff @(posedge wb_clk or negedge wb_rstn) begin
    if (!wb_rstn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req & w_full) r_overrun <= 1'b1;
      else if (w_ovr_clr)      r_overrun <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rstn) begin
    if (!wb_rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div_lat <= DIV_INIT;
      r_bit     <= '0;
      r_shift   <= '0;
    end else begin
      if (w_pop) begin
        r_shift   <= r_mem[r_rptr];
        r_div_lat <= r_div;
        r_cnt     <= r_div - 16'd1;
        r_state   <= S_START;
      end else begin
        case (r_state)
          S_START: begin
            if (w_phase_end) begin
              r_cnt   <= r_div_lat - 16'd1;
              r_bit   <= '0;
              r_state <= S_DATA;
            end else r_cnt <= r_cnt - 16'd1;
          end
          S_DATA: begin
            if (w_phase_end) begin
              r_cnt   <= r_div_lat - 16'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= S_STOP;
            end else r_cnt <= r_cnt - 16'd1;
          end
          S_STOP: begin
            if (w_phase_end) r_state <= S_IDLE;
            else             r_cnt   <= r_cnt - 16'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Output register trails the FSM by one cycle so each symbol still lasts the full divisor.
  always_ff @(posedge wb_clk or negedge wb_rstn) begin
    if (!wb_rstn) begin
      r_tx      <= 1'b1;
      r_tx_idle <= 1'b1;
    end else begin
      case (r_state)
        S_START: r_tx <= 1'b0;
        S_DATA:  r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
      r_tx_idle <= w_empty & (r_state == S_IDLE);
    end
  end

  assign o_wb_ack  = r_ack;
  assign o_wb_rdt  = r_rdt;
  assign o_tx      = r_tx;
  assign o_tx_idle = r_tx_idle;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: bus accesses, frame timing bit by bit,
// FIFO overrun, divisor handling and asynchronous reset mid-frame.
module tb_wb_uart_tx;

  logic        wb_clk = 1'b0;
  logic        wb_rstn;
  logic [3:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        o_tx;
  logic        o_tx_idle;

  int total = 0;
  int bad   = 0;

  wb_uart_tx #(.DIV_RESET(234), .FIFO_DEPTH(4)) dut (
    .wb_clk    (wb_clk),
    .wb_rstn   (wb_rstn),
    .i_wb_adr  (i_wb_adr),
    .i_wb_dat  (i_wb_dat),
    .i_wb_sel  (i_wb_sel),
    .i_wb_we   (i_wb_we),
    .i_wb_cyc  (i_wb_cyc),
    .o_wb_rdt  (o_wb_rdt),
    .o_wb_ack  (o_wb_ack),
    .o_tx      (o_tx),
    .o_tx_idle (o_tx_idle)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Entered and left 1 ns after a rising edge; the access edge is the next one.
  task automatic bus(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic we, output logic [31:0] rdata);
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we; i_wb_cyc = 1'b1;
    chk("ack_pre", 32'(o_wb_ack), 32'd0);
    @(posedge wb_clk); #1;
    chk("ack", 32'(o_wb_ack), 32'd1);
    rdata = o_wb_rdt;
    i_wb_cyc = 1'b0;
    @(posedge wb_clk); #1;
    chk("ack_drop", 32'(o_wb_ack), 32'd0);
    chk("rdt_idle", o_wb_rdt, 32'd0);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] v;
    bus(adr, dat, sel, 1'b1, v);
  endtask

  task automatic rdc(input logic [3:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    bus(adr, 32'd0, 4'hF, 1'b0, v);
    chk(tag, v, exp);
  endtask

  // Checks o_tx every cycle of an 8N1 frame from cycle index 'skip' to the end.
  task automatic check_frame(input logic [7:0] b, input int div, input int skip, input string tag);
    int  pos;
    logic e;
    for (int i = skip; i < 10 * div; i++) begin
      pos = i / div;
      if (pos == 0)      e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else               e = b[pos-1];
      chk(tag, 32'(o_tx), 32'(e));
      @(posedge wb_clk); #1;
    end
  endtask

  initial begin
    logic [7:0] fill [6];
    fill = '{8'hF0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    wb_rstn = 1'b0; i_wb_cyc = 1'b0; i_wb_we = 1'b0;
    i_wb_adr = '0; i_wb_dat = '0; i_wb_sel = '0;
    repeat (2) @(posedge wb_clk); #1;
    chk("rst_tx",   32'(o_tx),      32'd1);
    chk("rst_ack",  32'(o_wb_ack),  32'd0);
    chk("rst_rdt",  o_wb_rdt,       32'd0);
    chk("rst_idle", 32'(o_tx_idle), 32'd1);
    wb_rstn = 1'b1;
    @(posedge wb_clk); #1;
    rdc(4'h4, 32'h0000_0001, "status_rst");
    rdc(4'h8, 32'd234,       "div_rst");

    // single frame, divisor 4
    wr(4'h8, 32'd4, 4'b0011);
    rdc(4'h8, 32'd4, "div4");
    wr(4'h0, 32'h55, 4'b0001);
    @(posedge wb_clk); #1;
    chk("idle_busy", 32'(o_tx_idle), 32'd0);
    check_frame(8'h55, 4, 0, "frame_55");
    chk("idle_after_55", 32'(o_tx_idle), 32'd1);

    // three queued frames must run back to back
    wr(4'h8, 32'd2, 4'b0011);
    wr(4'h0, 32'hA5, 4'b0001);
    wr(4'h0, 32'h3C, 4'b0001);
    wr(4'h0, 32'h01, 4'b0001);
    check_frame(8'hA5, 2, 3, "frame_A5");
    check_frame(8'h3C, 2, 0, "frame_3C");
    check_frame(8'h01, 2, 0, "frame_01");
    chk("idle_after_b2b", 32'(o_tx_idle), 32'd1);

    // overfill: one byte in shifter, four queued, sixth dropped
    wr(4'h8, 32'd20, 4'b0011);
    for (int k = 1; k <= 6; k++) wr(4'h0, 32'(k * 17), 4'b0001);
    rdc(4'h4, 32'h0000_0486, "status_full_ovr");
    wr(4'h4, 32'h80, 4'b0001);
    rdc(4'h4, 32'h0000_0406, "status_ovr_clr");
    check_frame(8'h11, 20, 15, "frame_ovr1");
    check_frame(8'h22, 20, 0,  "frame_ovr2");
    check_frame(8'h33, 20, 0,  "frame_ovr3");
    check_frame(8'h44, 20, 0,  "frame_ovr4");
    check_frame(8'h55, 20, 0,  "frame_ovr5");
    chk("idle_after_ovr", 32'(o_tx_idle), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("tx_high_after_ovr", 32'(o_tx), 32'd1);
      @(posedge wb_clk); #1;
    end
    rdc(4'h4, 32'h0000_0001, "status_drained");

    // divisor boundaries and byte enables
    wr(4'h8, 32'd0, 4'b0011);
    rdc(4'h8, 32'd1, "div_zero_as_one");
    wr(4'h0, 32'h0F, 4'b0001);
    @(posedge wb_clk); #1;
    check_frame(8'h0F, 1, 0, "frame_div1");
    chk("idle_after_div1", 32'(o_tx_idle), 32'd1);
    wr(4'h8, 32'h5600, 4'b0011);
    rdc(4'h8, 32'h0000_5600, "div_5600");
    wr(4'h8, 32'h1234, 4'b0001);
    rdc(4'h8, 32'h0000_5634, "div_low_byte");

    // reset in the middle of the data bits
    wr(4'h8, 32'd4, 4'b0011);
    for (int k = 0; k < 6; k++) wr(4'h0, 32'(fill[k]), 4'b0001);
    rdc(4'h4, 32'h0000_0486, "status_pre_rst");
    chk("tx_bit1_pre_rst", 32'(o_tx), 32'd0);
    #2 wb_rstn = 1'b0;
    #1;
    chk("tx_async_rst",   32'(o_tx),      32'd1);
    chk("idle_async_rst", 32'(o_tx_idle), 32'd1);
    chk("ack_async_rst",  32'(o_wb_ack),  32'd0);
    @(posedge wb_clk); #1;
    wb_rstn = 1'b1;
    @(posedge wb_clk); #1;
    rdc(4'h4, 32'h0000_0001, "status_post_rst");
    rdc(4'h8, 32'd234,       "div_post_rst");
    for (int k = 0; k < 4; k++) begin
      chk("tx_high_post_rst", 32'(o_tx), 32'd1);
      @(posedge wb_clk); #1;
    end

    // reserved and write-only reads, reserved write ignored
    rdc(4'hC, 32'd0, "rsvd_read");
    rdc(4'h0, 32'd0, "data_read");
    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    rdc(4'h8, 32'd234, "div_after_rsvd_wr");

    // continuous cyc: ack alternates
    i_wb_adr = 4'h4; i_wb_we = 1'b0; i_wb_sel = 4'hF; i_wb_cyc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge wb_clk); #1;
      chk("ack_toggle", 32'(o_wb_ack), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rdt_toggle", o_wb_rdt, (k % 2 == 0) ? 32'h0000_0001 : 32'd0);
    end
    i_wb_cyc = 1'b0;
    @(posedge wb_clk); #1;
    chk("ack_end", 32'(o_wb_ack), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
